// File: rtl/pic_pkg.sv
// Shared constants for the priority-interrupt controller: register map,
// CFG/EOI bit positions and the acknowledge-sequence state encoding.
package pic_pkg;

   localparam logic [1:0] ADDR_CFG  = 2'd0;
   localparam logic [1:0] ADDR_IMR  = 2'd1;
   localparam logic [1:0] ADDR_BASE = 2'd2;
   localparam logic [1:0] ADDR_EOI  = 2'd3;

   localparam logic [1:0] RADDR_IRR      = 2'd0;
   localparam logic [1:0] RADDR_IMR      = 2'd1;
   localparam logic [1:0] RADDR_ISR      = 2'd2;
   localparam logic [1:0] RADDR_BASE_CFG = 2'd3;

   localparam int CFG_LTIM     = 0;
   localparam int CFG_AEOI     = 1;
   localparam int CFG_ROT      = 2;
   localparam int CFG_W        = 3;
   localparam int EOI_SPECIFIC = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK1 = 2'd2
   } state_t;

endpackage

// File: rtl/pic_prio_resolver.sv
// Rotating priority encoder: channel ptr is highest priority, then ptr+1, ...
// wrapping modulo NCH. Returns the winning channel id.
module pic_prio_resolver #(
   parameter int NCH  = 8,
   parameter int ID_W = $clog2(NCH)
) (
   input  logic [NCH-1:0]  req,
   input  logic [ID_W-1:0] ptr,
   output logic            valid,
   output logic [ID_W-1:0] id
);

   localparam logic [ID_W:0] NCH_W = (ID_W+1)'(NCH);

   logic [NCH-1:0]  rot;
   logic [ID_W-1:0] pos;
   logic [ID_W:0]   sum;

   // Bit i of rot is channel (i + ptr) mod NCH, so the lowest set bit wins.
   assign rot   = NCH'({req, req} >> ptr);
   assign valid = |req;

   always_comb begin
      pos = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (rot[i]) pos = ID_W'(i);
      end
   end

   assign sum = {1'b0, pos} + {1'b0, ptr};
   assign id  = (sum >= NCH_W) ? ID_W'(sum - NCH_W) : sum[ID_W-1:0];

endmodule

// File: rtl/pic_prio_ctrl.sv
// Priority-interrupt control core: IRR/IMR/ISR bookkeeping, nested or
// rotating priority, intr generation and the two-pulse inta vector sequence.
module pic_prio_ctrl
   import pic_pkg::*;
#(
   parameter int NCH   = 8,
   parameter int VEC_W = 8,
   parameter int ID_W  = $clog2(NCH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NCH-1:0]   ir,
   input  logic             wr,
   input  logic [1:0]       addr,
   input  logic [15:0]      wdata,
   input  logic [1:0]       raddr,
   output logic [15:0]      rdata,
   output logic             intr,
   input  logic             inta,
   output logic [VEC_W-1:0] vec,
   output logic             vec_valid
);

   localparam logic [ID_W:0] NCH_W = (ID_W+1)'(NCH);

   logic [NCH-1:0]   irr_reg, imr_reg, isr_reg, ir_q_reg;
   logic [CFG_W-1:0] cfg_reg;
   logic [VEC_W-1:0] base_reg, vec_reg;
   logic [ID_W-1:0]  ptr_reg, id_reg;
   state_t           state_reg;
   logic             spur_reg, intr_reg, vec_valid_reg;

   logic [NCH-1:0]   elig, irr_next, isr_next, isr_set, isr_clr, irr_clr;
   logic [ID_W-1:0]  elig_id, isr_id, eoi_id, ptr_next;
   logic             elig_valid, isr_valid, intr_cond;
   logic             ack1, ack2, aeoi_fire, eoi_wr, eoi_hit;
   logic             wdata_unused;

   function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] ch);
      return (int'(ch) == NCH - 1) ? '0 : ch + 1'b1;
   endfunction

   // Distance from the pointer; 0 is the highest priority.
   function automatic logic [ID_W-1:0] rank(input logic [ID_W-1:0] ch,
                                            input logic [ID_W-1:0] p);
      logic [ID_W:0] d;
      d = {1'b0, ch} + NCH_W - {1'b0, p};
      return (d >= NCH_W) ? ID_W'(d - NCH_W) : d[ID_W-1:0];
   endfunction

   assign elig = irr_reg & ~imr_reg;

   pic_prio_resolver #(.NCH(NCH), .ID_W(ID_W)) u_elig_res (
      .req   (elig),
      .ptr   (ptr_reg),
      .valid (elig_valid),
      .id    (elig_id)
   );

   pic_prio_resolver #(.NCH(NCH), .ID_W(ID_W)) u_isr_res (
      .req   (isr_reg),
      .ptr   (ptr_reg),
      .valid (isr_valid),
      .id    (isr_id)
   );

   assign intr_cond = elig_valid &&
                      (!isr_valid || (rank(elig_id, ptr_reg) < rank(isr_id, ptr_reg)));
   assign ack1      = (state_reg == REQ) && inta;
   assign ack2      = (state_reg == ACK1) && inta;
   assign aeoi_fire = ack2 && cfg_reg[CFG_AEOI] && !spur_reg;
   assign eoi_wr    = wr && (addr == ADDR_EOI);

   // A specific EOI aimed at the channel currently mid-acknowledge is dropped.
   always_comb begin
      eoi_hit = 1'b0;
      eoi_id  = '0;
      if (eoi_wr) begin
         if (wdata[EOI_SPECIFIC]) begin
            for (int i = 0; i < NCH; i++) begin
               if ((wdata[3:0] == 4'(i)) && isr_reg[i] &&
                   !((state_reg == ACK1) && !spur_reg && (id_reg == ID_W'(i)))) begin
                  eoi_hit = 1'b1;
                  eoi_id  = ID_W'(i);
               end
            end
         end else begin
            eoi_hit = isr_valid;
            eoi_id  = isr_id;
         end
      end
   end

   always_comb begin
      ptr_next = ptr_reg;
      if (cfg_reg[CFG_ROT]) begin
         if (eoi_hit)        ptr_next = wrap_inc(eoi_id);
         else if (aeoi_fire) ptr_next = wrap_inc(id_reg);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         assign isr_set[gi]  = ack1 && elig_valid && (elig_id == ID_W'(gi));
         assign irr_clr[gi]  = isr_set[gi] && !cfg_reg[CFG_LTIM];
         assign isr_clr[gi]  = (eoi_hit && (eoi_id == ID_W'(gi))) ||
                               (aeoi_fire && (id_reg == ID_W'(gi)));
         // A fresh edge during its own acknowledge stays pending.
         assign irr_next[gi] = cfg_reg[CFG_LTIM] ? ir[gi] :
                               ((irr_reg[gi] & ~irr_clr[gi]) | (ir[gi] & ~ir_q_reg[gi]));
      end
   endgenerate

   assign isr_next = (isr_reg & ~isr_clr) | isr_set;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irr_reg  <= '0;
         imr_reg  <= '1;
         isr_reg  <= '0;
         ir_q_reg <= '0;
         cfg_reg  <= '0;
         base_reg <= '0;
         ptr_reg  <= '0;
      end else begin
         irr_reg  <= irr_next;
         isr_reg  <= isr_next;
         ir_q_reg <= ir;
         ptr_reg  <= ptr_next;
         if (wr) begin
            case (addr)
               ADDR_CFG:  cfg_reg  <= wdata[CFG_W-1:0];
               ADDR_IMR:  imr_reg  <= wdata[NCH-1:0];
               ADDR_BASE: base_reg <= wdata[VEC_W-1:0];
               default:   ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         intr_reg      <= 1'b0;
         vec_reg       <= '0;
         vec_valid_reg <= 1'b0;
         id_reg        <= '0;
         spur_reg      <= 1'b0;
      end else begin
         vec_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (intr_cond) begin
                  state_reg <= REQ;
                  intr_reg  <= 1'b1;
               end
            end
            REQ: begin
               if (inta) begin
                  state_reg <= ACK1;
                  intr_reg  <= 1'b0;
                  id_reg    <= elig_valid ? elig_id : ID_W'(NCH - 1);
                  spur_reg  <= !elig_valid;
               end else if (!intr_cond) begin
                  state_reg <= IDLE;
                  intr_reg  <= 1'b0;
               end
            end
            ACK1: begin
               if (inta) begin
                  state_reg     <= IDLE;
                  vec_reg       <= base_reg + VEC_W'(id_reg);
                  vec_valid_reg <= 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               intr_reg  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      rdata = '0;
      case (raddr)
         RADDR_IRR:      rdata = 16'(irr_reg);
         RADDR_IMR:      rdata = 16'(imr_reg);
         RADDR_ISR:      rdata = 16'(isr_reg);
         RADDR_BASE_CFG: rdata = 16'({base_reg, cfg_reg});
         default:        rdata = '0;
      endcase
   end

   assign intr         = intr_reg;
   assign vec          = vec_reg;
   assign vec_valid    = vec_valid_reg;
   assign wdata_unused = ^wdata;

endmodule
